throughout_stim_gen: RTL and testbench

- Stimulus transmitter for the `$rose(a) ##0 (a throughout b[*N])` checkers in the chap_2 benches.
- On a start request it drives a burst on a/b:
  - a rises;
  - b is held high for a programmed number of consecutive cycles while a stays high;
  - both then fall for a mandatory gap.
- Optional fault injection drops b, or a, on one selected burst cycle, so the bench exercises both the pass and fail paths of the checker.
- It sits between the bench sequencer and the DUT checker module inputs a, b, c.

---
 rtl/throughout_stim_pkg.sv | 30 +++
 rtl/throughout_stim_gen.sv | 156 +++++++++++++++
 tb/tb_throughout_stim_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/throughout_stim_pkg.sv
// -----------------------------------------------------------------------------
// throughout_stim_pkg
//   Shared types for the throughout_stim_gen burst transmitter: FSM state
//   encoding, fault-injection kind codes and the per-burst configuration
//   record captured when a burst is requested.
// -----------------------------------------------------------------------------
package throughout_stim_pkg;

    // Width of the burst-length / fault-index fields held in burst_cfg_t.
    // The generator's CNT_W parameter is expected to equal this value.
    localparam int CFG_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Fault kinds selected by inj_kind.
    localparam logic INJ_DROP_B = 1'b0;   // b low for one cycle, burst runs on
    localparam logic INJ_DROP_A = 1'b1;   // a low for one cycle, burst aborts

    typedef struct packed {
        logic [CFG_CNT_W-1:0] reps_eff;   // effective burst length, never 0
        logic                 inj_en;
        logic                 inj_kind;
        logic [CFG_CNT_W-1:0] inj_idx;
    } burst_cfg_t;

endpackage : throughout_stim_pkg

// File: rtl/throughout_stim_gen.sv
// -----------------------------------------------------------------------------
// throughout_stim_gen
//   Drives a/b/c bursts for `$rose(a) ##0 (a throughout b[*N])` checkers.
//   A start request in IDLE launches a burst: a and b high for reps_eff
//   consecutive cycles (c marks the last one), then GAP idle cycles with
//   everything low so the next burst shows a fresh rising edge on a.
//   Optional fault injection drops b (burst continues) or a (burst aborts)
//   on one selected burst cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   burst request, sampled only in IDLE
//   reps       in   burst length, 0 selects B_REPS (latched at start)
//   inj_en     in   enable fault injection for this burst (latched)
//   inj_kind   in   0 = drop b, 1 = drop a (latched)
//   inj_idx    in   0-based burst cycle that receives the fault (latched)
//   a, b, c    out  checker stimulus; c marks the final burst cycle
//   busy       out  high while not in IDLE
//   done       out  one-cycle pulse on the first GAP cycle
//   burst_cnt  out  completed (normal or aborted) bursts, wraps
//
// All outputs are registered. They are computed from the *next* state so
// that a burst becomes visible on the cycle right after start is sampled.
// -----------------------------------------------------------------------------
module throughout_stim_gen
    import throughout_stim_pkg::*;
#(
    parameter int B_REPS = 3,
    parameter int CNT_W  = 4,
    parameter int GAP    = 1,     // must be >= 1
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  reps,
    input  logic              inj_en,
    input  logic              inj_kind,
    input  logic [CNT_W-1:0]  inj_idx,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              busy,
    output logic              done,
    output logic [BCNT_W-1:0] burst_cnt
);

    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] B_REPS_C = CNT_W'(B_REPS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    burst_cfg_t         cfg, cfg_n;

    logic last, abort, finish;
    logic inj_hit_n;
    logic a_n, b_n, c_n;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_n   = state;
        cnt_n     = cnt;
        gap_cnt_n = gap_cnt;
        cfg_n     = cfg;
        finish    = 1'b0;

        last  = (cnt == cfg.reps_eff - CNT_W'(1));
        abort = cfg.inj_en && (cfg.inj_kind == INJ_DROP_A) && (cnt == cfg.inj_idx);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    cfg_n.reps_eff = (reps == '0) ? B_REPS_C : reps;
                    cfg_n.inj_en   = inj_en;
                    cfg_n.inj_kind = inj_kind;
                    cfg_n.inj_idx  = inj_idx;
                    cnt_n          = '0;
                    state_n        = ST_BURST;
                end
            end
            ST_BURST: begin
                if (last || abort) begin
                    state_n   = ST_GAP;
                    gap_cnt_n = '0;
                    finish    = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output lookahead: what the pins must show in the cycle that follows the
    // coming edge. Outside BURST cnt_n is stale, so everything is gated.
    // -------------------------------------------------------------------------
    always_comb begin
        inj_hit_n = cfg_n.inj_en && (cnt_n == cfg_n.inj_idx);
        a_n = (state_n == ST_BURST) && !(inj_hit_n && (cfg_n.inj_kind == INJ_DROP_A));
        b_n = (state_n == ST_BURST) && !(inj_hit_n && (cfg_n.inj_kind == INJ_DROP_B));
        c_n = (state_n == ST_BURST) &&
              ((cnt_n == cfg_n.reps_eff - CNT_W'(1)) ||
               (inj_hit_n && (cfg_n.inj_kind == INJ_DROP_A)));
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset covers every register including the latched
            // configuration; an aborted burst must not leak into the next.
            state     <= ST_IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            cfg       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gap_cnt <= gap_cnt_n;
            cfg     <= cfg_n;
            a       <= a_n;
            b       <= b_n;
            c       <= c_n;
            busy    <= (state_n != ST_IDLE);
            done    <= finish;
            if (finish) begin
                burst_cnt <= burst_cnt + BCNT_W'(1);
            end
        end
    end

endmodule : throughout_stim_gen

// File: tb/tb_throughout_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_throughout_stim_gen
//   Scoreboard bench: each issued burst pushes its expected per-cycle a/b/c
//   beats and its done pulse (cycle + burst count) into queues; an
//   independent monitor pops and compares whenever the DUT shows activity.
//   burst_cnt is narrowed to 5 bits so the wrap is reached in a few hundred
//   cycles.
// -----------------------------------------------------------------------------
module tb_throughout_stim_gen;
    import throughout_stim_pkg::*;

    localparam int CNT_W  = 4;
    localparam int B_REPS = 3;
    localparam int GAP    = 1;
    localparam int BCNT_W = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  reps;
    logic              inj_en;
    logic              inj_kind;
    logic [CNT_W-1:0]  inj_idx;
    logic              a, b, c, busy, done;
    logic [BCNT_W-1:0] burst_cnt;

    throughout_stim_gen #(
        .B_REPS(B_REPS), .CNT_W(CNT_W), .GAP(GAP), .BCNT_W(BCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .reps(reps),
        .inj_en(inj_en), .inj_kind(inj_kind), .inj_idx(inj_idx),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .burst_cnt(burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen; an output sampled at a negedge belongs to
    // the cycle numbered by the edge that produced it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic a; logic b; logic c; } beat_t;
    typedef struct { int cyc; logic [BCNT_W-1:0] cnt; } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;
    logic [BCNT_W-1:0] exp_bcnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats for one burst starting in cycle t0; len returns the
    // number of burst cycles actually driven (shorter when a is dropped).
    task automatic push_burst(input int t0, input int reps_in, input bit en,
                              input bit kind, input int idx, output int len);
        int n;
        n   = (reps_in == 0) ? B_REPS : reps_in;
        len = n;
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.cyc = t0 + i;
            e.a   = 1'b1;
            e.b   = 1'b1;
            e.c   = (i == n - 1);
            if (en && i == idx) begin
                if (kind) begin
                    e.a = 1'b0;
                    e.c = 1'b1;
                    len = i + 1;
                end else begin
                    e.b = 1'b0;
                end
            end
            beat_q.push_back(e);
            if (len == i + 1) break;
        end
        exp_bcnt++;
        done_q.push_back('{t0 + len, exp_bcnt});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drive_cfg(input int reps_in, input bit en, input bit kind, input int idx);
        reps     = CNT_W'(reps_in);
        inj_en   = en;
        inj_kind = kind;
        inj_idx  = CNT_W'(idx);
        start    = 1'b1;
    endtask

    task automatic clear_cfg();
        start    = 1'b0;
        reps     = '0;
        inj_en   = 1'b0;
        inj_kind = 1'b0;
        inj_idx  = '0;
    endtask

    task automatic issue(input int reps_in, input bit en, input bit kind, input int idx);
        int len;
        @(negedge clk);
        drive_cfg(reps_in, en, kind, idx);
        push_burst(cyc + 1, reps_in, en, kind, idx, len);
        @(posedge clk);
        #1 clear_cfg();
        wait_idle();
    endtask

    // Hold start for period*nb edges: exactly nb back-to-back bursts.
    task automatic hold(input int reps_in, input int nb);
        int t0, len, period;
        @(negedge clk);
        drive_cfg(reps_in, 1'b0, 1'b0, 0);
        t0     = cyc + 1;
        period = 0;
        for (int i = 0; i < nb; i++) begin
            push_burst(t0 + i * period, reps_in, 1'b0, 1'b0, 0, len);
            period = len + GAP + 1;
        end
        repeat (period * nb) @(posedge clk);
        #1 clear_cfg();
        wait_idle();
    endtask

    // Monitor: compares every active output cycle and every done pulse.
    always @(negedge clk) begin
        beat_t e;
        done_t d;
        if (a || b || c) begin
            if (beat_q.size() == 0) begin
                check("beat_unexpected", {29'd0, a, b, c}, 32'd0);
            end else begin
                e = beat_q.pop_front();
                check("beat_cycle", cyc, e.cyc);
                check("beat_abc", {29'd0, a, b, c}, {29'd0, e.a, e.b, e.c});
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("done_bcnt", {27'd0, burst_cnt}, {27'd0, d.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        clear_cfg();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_a", {31'd0, a}, 32'd0);
        check("rst_b", {31'd0, b}, 32'd0);
        check("rst_c", {31'd0, c}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcnt", {27'd0, burst_cnt}, 32'd0);

        // Reset during burst cycle 1: two beats seen, then silence, no done
        @(negedge clk);
        drive_cfg(3, 1'b0, 1'b0, 0);
        t0 = cyc + 1;
        beat_q.push_back('{t0, 1'b1, 1'b1, 1'b0});
        beat_q.push_back('{t0 + 1, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1 clear_cfg();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_a", {31'd0, a}, 32'd0);
        check("abort_b", {31'd0, b}, 32'd0);
        check("abort_c", {31'd0, c}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcnt", {27'd0, burst_cnt}, 32'd0);
        repeat (4) @(negedge clk);

        // Directed bursts
        issue(0, 1'b0, INJ_DROP_B, 0);   // default length 3
        issue(5, 1'b1, INJ_DROP_B, 2);   // b dropped in cycle 2
        issue(4, 1'b1, INJ_DROP_A, 1);   // a dropped in cycle 1, abort
        issue(3, 1'b1, INJ_DROP_B, 7);   // index beyond burst: legal
        issue(1, 1'b0, INJ_DROP_B, 0);   // single-cycle burst
        issue(1, 1'b1, INJ_DROP_A, 0);   // abort on the only cycle
        issue(3, 1'b1, INJ_DROP_A, 2);   // abort on the last cycle

        // Back-to-back with start held: 4 bursts, period 5
        hold(3, 4);

        // Enough short bursts to wrap the 5-bit burst counter
        hold(1, 24);
        check("wrap_final", {27'd0, burst_cnt}, {27'd0, exp_bcnt});

        repeat (3) @(negedge clk);
        check("beats_left", beat_q.size(), 32'd0);
        check("dones_left", done_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_throughout_stim_gen
